// File: rtl/umi_gpio_initiator.sv
// umi_gpio_initiator
//   UMI initiator for a remote umi_gpio responder over a 256-bit UMI link.
//   The local drive vector is mirrored to the remote GPIO output register with
//   posted writes whenever it changes. The remote GPIO input register is polled
//   with periodic read requests, and the returned value is presented locally.
//
// Ports
//   clk            : clock
//   nreset         : synchronous, active-high reset
//   drive_in       : value to mirror onto the remote gpio_out
//   poll_en        : enables periodic reads
//   sense_out      : last read data returned by the remote
//   sense_valid    : one-cycle pulse when sense_out updates
//   busy           : write pending, read outstanding or request valid
//   unexpected     : one-cycle pulse on an inbound packet that was not awaited
//   umi_out_*      : request channel (valid/ready/packet)
//   umi_in_*       : response channel (valid/ready/packet)
//   timeout_err    : sticky read-timeout flag (only with the macro below)
//
// Build option
//   UMI_GPIO_INITIATOR_TIMEOUT_EN : adds parameter TIMEOUT and output
//   timeout_err. A read with no response within TIMEOUT cycles is abandoned.

module umi_gpio_initiator #(
   parameter int          UW          = 256,
   parameter int          WWIDTH      = 32,
   parameter int          RWIDTH      = 32,
   parameter logic [63:0] DST_ADDR    = 64'h0,
   parameter logic [63:0] SRC_ADDR    = 64'h0,
   parameter int          POLL_CYCLES = 1024
`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
   ,
   parameter int          TIMEOUT     = 4096
`endif
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [WWIDTH-1:0] drive_in,
   input  logic              poll_en,
   output logic [RWIDTH-1:0] sense_out,
   output logic              sense_valid,
   output logic              busy,
   output logic              unexpected,
   output logic              umi_out_valid,
   output logic [UW-1:0]     umi_out_packet,
   input  logic              umi_out_ready,
   input  logic              umi_in_valid,
   input  logic [UW-1:0]     umi_in_packet,
   output logic              umi_in_ready
`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   localparam logic [7:0] OP_WRITE_POSTED = 8'h01;
   localparam logic [7:0] OP_READ_REQ     = 8'h08;
   localparam logic [7:0] OP_READ_RESP    = 8'h09;

   // size field is log2 of the byte count, rounded up
   localparam logic [3:0] WSIZE = 4'($clog2((WWIDTH + 7) / 8));
   localparam logic [3:0] RSIZE = 4'($clog2((RWIDTH + 7) / 8));

   localparam int PCW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_WR   = 2'd1,
      SEND_RD   = 2'd2,
      WAIT_RESP = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WWIDTH-1:0] shadow;
   logic             write_pending;
   logic             wp_nxt;
   logic             read_pending;
   logic [PCW-1:0]   poll_cnt;
   logic             out_hs;
   logic             in_acc;
   logic             resp_ok;
   logic             start_wr;
   logic             start_rd;
   logic             rd_outstanding;
   logic             tmo;
   logic             unused_in_bits;

   // Assemble a request packet addressed to the remote GPIO block
   function automatic logic [UW-1:0] make_pkt(input logic [7:0]  opcode,
                                              input logic [3:0]  size,
                                              input logic [95:0] data);
      logic [UW-1:0] pkt;
      pkt          = '0;
      pkt[7:0]     = opcode;
      pkt[11:8]    = size;
      pkt[95:32]   = DST_ADDR;
      pkt[159:96]  = SRC_ADDR;
      pkt[255:160] = data;
      return pkt;
   endfunction

   assign out_hs   = umi_out_valid & umi_out_ready;
   assign in_acc   = umi_in_valid & umi_in_ready;
   assign resp_ok  = in_acc && (state == WAIT_RESP) &&
                     (umi_in_packet[7:0] == OP_READ_RESP) &&
                     (umi_in_packet[95:32] == SRC_ADDR);
   assign start_wr = (state == IDLE) && write_pending;
   assign start_rd = (state == IDLE) && !write_pending && read_pending;
   // the poll period restarts only once the previous read has fully retired
   assign rd_outstanding = read_pending || (state == SEND_RD) || (state == WAIT_RESP);
   // forming a write consumes the pending change; a later mismatch re-arms it
   assign wp_nxt = start_wr ? 1'b0 :
                   ((drive_in != shadow) ? 1'b1 : write_pending);

   // size field and source address of responses are not needed
   assign unused_in_bits = ^{umi_in_packet[31:8], umi_in_packet[UW-1:96]};

`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmo_cnt;

   assign tmo = (state == WAIT_RESP) && (tmo_cnt == TW'(TIMEOUT - 1)) && !resp_ok;

   // Response timeout counter and sticky error flag
   always_ff @(posedge clk) begin
      if (nreset) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if ((state == WAIT_RESP) && !resp_ok && !tmo) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end else begin
            tmo_cnt <= '0;
         end
         if (tmo) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign tmo = 1'b0;
`endif

   // Next-state decode; writes win over reads
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (write_pending) begin
               state_nxt = SEND_WR;
            end else if (read_pending) begin
               state_nxt = SEND_RD;
            end else begin
               state_nxt = IDLE;
            end
         end
         SEND_WR: begin
            if (out_hs) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = SEND_WR;
            end
         end
         SEND_RD: begin
            if (out_hs) begin
               state_nxt = WAIT_RESP;
            end else begin
               state_nxt = SEND_RD;
            end
         end
         WAIT_RESP: begin
            if (resp_ok || tmo) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT_RESP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request FSM, poll timer, response capture and registered outputs
   always_ff @(posedge clk) begin
      if (nreset) begin
         state          <= IDLE;
         shadow         <= '0;
         write_pending  <= 1'b1;
         read_pending   <= 1'b0;
         poll_cnt       <= '0;
         busy           <= 1'b0;
         sense_out      <= '0;
         sense_valid    <= 1'b0;
         unexpected     <= 1'b0;
         umi_out_valid  <= 1'b0;
         umi_out_packet <= '0;
         umi_in_ready   <= 1'b0;
      end else begin
         state         <= state_nxt;
         write_pending <= wp_nxt;
         busy          <= wp_nxt | (state_nxt != IDLE);
         umi_in_ready  <= 1'b1;

         // valid only rises from IDLE, so packet is never rewritten mid-offer
         if (start_wr) begin
            shadow         <= drive_in;
            umi_out_packet <= make_pkt(OP_WRITE_POSTED, WSIZE, 96'(drive_in));
            umi_out_valid  <= 1'b1;
         end else if (start_rd) begin
            umi_out_packet <= make_pkt(OP_READ_REQ, RSIZE, 96'd0);
            umi_out_valid  <= 1'b1;
         end else if (out_hs) begin
            umi_out_valid  <= 1'b0;
         end

         if (!poll_en) begin
            poll_cnt     <= '0;
            read_pending <= 1'b0;
         end else if (start_rd) begin
            read_pending <= 1'b0;
         end else if (!rd_outstanding) begin
            if (poll_cnt == PCW'(POLL_CYCLES - 1)) begin
               poll_cnt     <= '0;
               read_pending <= 1'b1;
            end else begin
               poll_cnt     <= poll_cnt + PCW'(1);
            end
         end

         sense_valid <= resp_ok;
         if (resp_ok) begin
            sense_out <= umi_in_packet[160 +: RWIDTH];
         end
         unexpected <= in_acc & ~resp_ok;
      end
   end

endmodule

// File: tb/tb_umi_gpio_initiator.sv
// Self-checking bench for umi_gpio_initiator: expected requests and sense
// values are queued when stimulus is applied and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_umi_gpio_initiator;

   localparam logic [63:0] DST = 64'h0000_0000_4000_0000;
   localparam logic [63:0] SRC = 64'h0000_0000_0000_1000;

   logic         clk = 1'b0;
   logic         nreset;
   logic [31:0]  drive_in;
   logic         poll_en;
   logic [31:0]  sense_out;
   logic         sense_valid;
   logic         busy;
   logic         unexpected;
   logic         umi_out_valid;
   logic [255:0] umi_out_packet;
   logic         umi_out_ready;
   logic         umi_in_valid;
   logic [255:0] umi_in_packet;
   logic         umi_in_ready;
`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
   logic         timeout_err;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int rd_cyc = 0;
   int unexp_cnt = 0;
   int exp_unexp = 0;
   logic [255:0] exp_q[$];
   logic [31:0]  sense_q[$];
   logic [255:0] mon_e;

   umi_gpio_initiator #(
      .UW(256), .WWIDTH(32), .RWIDTH(32),
      .DST_ADDR(DST), .SRC_ADDR(SRC), .POLL_CYCLES(16)
`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
   ) dut (
      .clk(clk), .nreset(nreset), .drive_in(drive_in), .poll_en(poll_en),
      .sense_out(sense_out), .sense_valid(sense_valid), .busy(busy),
      .unexpected(unexpected), .umi_out_valid(umi_out_valid),
      .umi_out_packet(umi_out_packet), .umi_out_ready(umi_out_ready),
      .umi_in_valid(umi_in_valid), .umi_in_packet(umi_in_packet),
      .umi_in_ready(umi_in_ready)
`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mk_pkt(input logic [7:0] op, input logic [63:0] dst,
                                           input logic [63:0] src, input logic [31:0] data);
      logic [255:0] p;
      p          = '0;
      p[7:0]     = op;
      p[11:8]    = 4'd2;
      p[95:32]   = dst;
      p[159:96]  = src;
      p[255:160] = {64'd0, data};
      return p;
   endfunction

   function automatic logic [255:0] wr(input logic [31:0] v);
      return mk_pkt(8'h01, DST, SRC, v);
   endfunction

   function automatic logic [255:0] rd();
      return mk_pkt(8'h08, DST, SRC, 32'd0);
   endfunction

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!nreset && umi_out_valid && umi_out_ready) begin
         check_eq("req_expected", 256'(exp_q.size() != 0), 256'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e[7:0] == 8'h08) check_eq("rd_req", 256'(umi_out_packet[159:0]), 256'(mon_e[159:0]));
            else check_eq("wr_req", umi_out_packet, mon_e);
         end
         if (umi_out_packet[7:0] == 8'h08) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc = cyc;
         end
      end
      if (!nreset && sense_valid) begin
         check_eq("sense_expected", 256'(sense_q.size() != 0), 256'd1);
         if (sense_q.size() != 0) check_eq("sense_data", 256'(sense_out), 256'(sense_q.pop_front()));
      end
      if (!nreset && unexpected) unexp_cnt = unexp_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      check_eq(tag, 256'(exp_q.size()), 256'd0);
   endtask

   task automatic wait_rd(input int base);
      int n;
      n = 0;
      while (rd_cnt == base && n < 60) begin
         tick();
         n++;
      end
      check_eq("rd_seen", 256'(rd_cnt != base), 256'd1);
   endtask

   // Wait for the next read request, then answer it (optionally after a misaddressed one)
   task automatic respond(input logic [31:0] data, input bit bad_first, input bit poll_off,
                          output int acc_cyc);
      wait_rd(rd_cnt);
      if (bad_first) begin
         umi_in_valid  = 1'b1;
         umi_in_packet = mk_pkt(8'h09, SRC ^ 64'h1, DST, data);
         exp_unexp++;
         tick();
      end
      umi_in_valid  = 1'b1;
      umi_in_packet = mk_pkt(8'h09, SRC, DST, data);
      sense_q.push_back(data);
      acc_cyc = cyc;
      if (poll_off) poll_en = 1'b0;
      tick();
      umi_in_valid  = 1'b0;
      umi_in_packet = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, acc3, d, n;
      nreset = 1'b1; drive_in = 32'hA5A5_0001; poll_en = 1'b0;
      umi_out_ready = 1'b1; umi_in_valid = 1'b0; umi_in_packet = '0;
      repeat (3) tick();
      check_eq("rst_valid", 256'(umi_out_valid), 256'd0);
      check_eq("rst_packet", umi_out_packet, 256'd0);
      check_eq("rst_in_ready", 256'(umi_in_ready), 256'd0);
      check_eq("rst_busy", 256'(busy), 256'd0);
      check_eq("rst_sense", 256'(sense_out), 256'd0);
      check_eq("rst_sense_valid", 256'(sense_valid), 256'd0);
      check_eq("rst_unexpected", 256'(unexpected), 256'd0);

      // first request after reset is a write of drive_in
      exp_q.push_back(wr(32'hA5A5_0001));
      nreset = 1'b0;
      drain("first_wr", 20);
      repeat (20) tick();
      check_eq("idle_busy", 256'(busy), 256'd0);
      check_eq("in_ready", 256'(umi_in_ready), 256'd1);

      // polling, including a misaddressed response while waiting
      poll_en = 1'b1;
      exp_q.push_back(rd());
      respond(32'h3, 1'b1, 1'b0, acc1);
      tick();
      check_eq("sense_pulse_end", 256'(sense_valid), 256'd0);
      check_eq("sense_val3", 256'(sense_out), 256'd3);
      exp_q.push_back(rd());
      respond(32'h5, 1'b0, 1'b1, acc2);
      d = rd_cyc - acc1;
      if (d < 17 || d > 19) check_eq("poll_period", 256'(d), 256'd18);
      else check_eq("poll_period", 256'd1, 256'(d >= 17));
      tick();
      check_eq("sense_val5", 256'(sense_out), 256'd5);
      repeat (25) tick();

      // stalled write with a change mid-stall
      umi_out_ready = 1'b0;
      drive_in = 32'h1;
      exp_q.push_back(wr(32'h1));
      n = 0;
      while (!umi_out_valid && n < 10) begin tick(); n++; end
      for (int i = 0; i < 10; i++) begin
         check_eq("stall_valid", 256'(umi_out_valid), 256'd1);
         check_eq("stall_pkt", umi_out_packet, wr(32'h1));
         if (i == 4) begin
            drive_in = 32'h2;
            exp_q.push_back(wr(32'h2));
         end
         tick();
      end
      check_eq("stall_busy", 256'(busy), 256'd1);
      umi_out_ready = 1'b1;
      drain("stall_drain", 20);
      repeat (4) tick();

      // write change and poll expiry land in the same cycle
      poll_en = 1'b1;
      repeat (15) tick();
      drive_in = 32'h3;
      exp_q.push_back(wr(32'h3));
      exp_q.push_back(rd());
      respond(32'h7, 1'b0, 1'b1, acc3);
      tick();
      check_eq("sense_val7", 256'(sense_out), 256'd7);
      drain("same_cycle_drain", 10);
      repeat (4) tick();

      // unsolicited inbound packets
      umi_in_valid = 1'b1; umi_in_packet = mk_pkt(8'h09, SRC, DST, 32'h9); exp_unexp++;
      tick();
      umi_in_valid = 1'b0;
      tick();
      umi_in_valid = 1'b1; umi_in_packet = mk_pkt(8'h01, SRC, DST, 32'h9); exp_unexp++;
      tick();
      umi_in_valid = 1'b0; umi_in_packet = '0;
      repeat (3) tick();
      check_eq("unexp_sense_kept", 256'(sense_out), 256'd7);
      check_eq("unexp_count", 256'(unexp_cnt), 256'(exp_unexp));

      // reset while a write is being offered
      umi_out_ready = 1'b0;
      drive_in = 32'h4;
      exp_q.push_back(wr(32'h4));
      n = 0;
      while (!umi_out_valid && n < 10) begin tick(); n++; end
      check_eq("pre_rst_valid", 256'(umi_out_valid), 256'd1);
      nreset = 1'b1;
      tick();
      check_eq("rst_drop_valid", 256'(umi_out_valid), 256'd0);
      nreset = 1'b0;
      umi_out_ready = 1'b1;
      drain("post_rst_wr", 20);
      repeat (3) tick();

`ifdef UMI_GPIO_INITIATOR_TIMEOUT_EN
      check_eq("tmo_clear", 256'(timeout_err), 256'd0);
      poll_en = 1'b1;
      exp_q.push_back(rd());
      wait_rd(rd_cnt);
      repeat (7) tick();
      check_eq("tmo_not_yet", 256'(timeout_err), 256'd0);
      tick();
      check_eq("tmo_set", 256'(timeout_err), 256'd1);
      umi_in_valid = 1'b1; umi_in_packet = mk_pkt(8'h09, SRC, DST, 32'hB); exp_unexp++;
      tick();
      umi_in_valid = 1'b0; umi_in_packet = '0;
      exp_q.push_back(rd());
      wait_rd(rd_cnt);
      poll_en = 1'b0;
      repeat (12) tick();
      check_eq("tmo_sticky", 256'(timeout_err), 256'd1);
      check_eq("tmo_sense_kept", 256'(sense_out), 256'd7);
      check_eq("late_unexp", 256'(unexp_cnt), 256'(exp_unexp));
`endif

      repeat (5) tick();
      check_eq("final_req_q", 256'(exp_q.size()), 256'd0);
      check_eq("final_sense_q", 256'(sense_q.size()), 256'd0);
      check_eq("final_unexp", 256'(unexp_cnt), 256'(exp_unexp));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/umi_gpio_initiator.md
Name: umi_gpio_initiator

Overview:
- UMI initiator that drives a remote umi_gpio responder over a 256-bit UMI link.
- Mirrors a local drive vector to the remote GPIO output register using posted writes, issued on change.
- Polls the remote GPIO input register with periodic read requests and presents the returned value locally.
- Sits on the host/testbench side of the link, facing the responder's inbound and outbound UMI ports.

Parameters:
- UW, 256, UMI packet width.
- WWIDTH, 32, drive vector width (max 96).
- RWIDTH, 32, sense vector width (max 96).
- DST_ADDR, 64'h0, remote GPIO base address placed in dstaddr.
- SRC_ADDR, 64'h0, own return address placed in srcaddr.
- POLL_CYCLES, 1024, cycles between read requests (min 2).

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-high.
- drive_in  in  WWIDTH  value to mirror onto the remote gpio_out.
- poll_en  in  1  enables periodic reads.
- sense_out  out  RWIDTH  last read data returned by the remote.
- sense_valid  out  1  one-cycle pulse when sense_out updates.
- busy  out  1  write pending, read outstanding, or out packet valid.
- unexpected  out  1  one-cycle pulse on an unexpected inbound packet.
- umi_out_valid  out  1  request valid.
- umi_out_packet  out  UW  request packet.
- umi_out_ready  in  1  request accepted.
- umi_in_valid  in  1  response valid.
- umi_in_packet  in  UW  response packet.
- umi_in_ready  out  1  response accept.

Behaviour:
- Packet layout:
  - [31:0] cmd, with opcode in [7:0] and size in [11:8] (log2 bytes).
  - [95:32] dstaddr; [159:96] srcaddr; [255:160] data, LSB-aligned.
  - Opcodes: WRITE_POSTED 8'h01, READ_REQ 8'h08, READ_RESP 8'h09.
  - Size field is 2 for 32-bit widths; otherwise it is ceil(log2(bytes)).
- Reset (nreset=1 at clk edge), all outputs registered:
  - sense_out=0, sense_valid=0, busy=0, unexpected=0.
  - umi_out_valid=0, umi_out_packet=0, umi_in_ready=0.
  - shadow register=0; poll counter=0; write_pending=1, so the first post-reset request is a write of drive_in.
  - Reset mid-transfer drops valid immediately. A response arriving after reset is treated as unexpected.
- Change detect:
  - write_pending sets whenever drive_in != shadow.
  - shadow loads drive_in when a write packet is formed.
  - A change during an in-flight write leaves write_pending set, so another write follows.
- Poll counter:
  - Counts only while poll_en=1 and no read is outstanding.
  - At POLL_CYCLES-1 it sets read_pending and wraps to 0.
  - poll_en=0 clears the counter and read_pending, but not an outstanding read.
- FSM states: IDLE, SEND_WR, SEND_RD, WAIT_RESP.
  - IDLE -> SEND_WR if write_pending. Writes have priority over reads.
  - IDLE -> SEND_RD if read_pending, otherwise stay in IDLE.
  - The packet is registered on entry to SEND_WR/SEND_RD and umi_out_valid=1 from the next cycle.
  - Packet and valid hold stable until umi_out_valid && umi_out_ready. Valid never drops without a handshake.
  - SEND_WR -> IDLE on handshake. SEND_RD -> WAIT_RESP on handshake.
  - WAIT_RESP -> IDLE on an accepted READ_RESP with dstaddr==SRC_ADDR.
  - On that response: sense_out <= data[RWIDTH-1:0], with a sense_valid pulse the cycle after acceptance.
  - No new read issues while in WAIT_RESP. Writes pending during WAIT_RESP issue only after return to IDLE.
  - Minimum request-to-request spacing: 1 idle cycle.
- Inbound:
  - umi_in_ready=1 whenever out of reset; any packet is consumed in 1 cycle.
  - Any packet other than a matching READ_RESP in WAIT_RESP pulses unexpected and is discarded.
  - This covers other opcodes, a wrong dstaddr, or arrival outside WAIT_RESP.
- busy = write_pending | (state != IDLE).

Optional Feature:
- Macro: UMI_GPIO_INITIATOR_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 4096) and output timeout_err (1 bit, sticky, cleared only by reset).
  - A TIMEOUT-cycle counter runs in WAIT_RESP. On expiry: timeout_err=1, FSM -> IDLE, sense_out unchanged.
  - A late response arriving afterwards pulses unexpected.
- When not defined: no timeout_err port, and WAIT_RESP waits indefinitely.

Test Plan:
- Reset release, drive_in=32'hA5A5_0001, out_ready=1:
  - First packet is opcode 8'h01, dstaddr=DST_ADDR, data[31:0]=32'hA5A5_0001.
  - No further write while drive_in is held.
- poll_en=1, POLL_CYCLES=16, responder returns READ_RESP with data 32'h0000_0003:
  - READ_REQ is issued.
  - After the response, sense_out=3 with a one-cycle sense_valid.
  - Next READ_REQ follows 16 cycles after IDLE is re-entered.
- out_ready held 0 for 10 cycles with a write pending:
  - valid and packet are stable all 10 cycles.
  - drive_in changes to 32'h2 mid-stall: the first write completes with the old value, then a second write carries 32'h2.
- Write change and poll expiry in the same cycle: write packet first, read request next.
- Unsolicited READ_RESP while IDLE, and a WRITE_POSTED inbound:
  - unexpected pulses once for each packet.
  - sense_out is unchanged.
- With UMI_GPIO_INITIATOR_TIMEOUT_EN and TIMEOUT=8, no response to a read:
  - timeout_err=1 after 8 cycles in WAIT_RESP, and polling resumes.
  - A late response pulses unexpected.
